// File: rtl/fwd_stall_ctrl_pkg.sv
// Shared constants for the forwarding/stall controller: forward-select codes and
// shadow-entry layout {vld, wr, ld, dst} with dst in the low REG_ADDR_W bits.
package fwd_stall_ctrl_pkg;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // Flag bits sit directly above dst; offsets are relative to REG_ADDR_W.
  localparam int unsigned ENT_FLAG_W  = 3;
  localparam int unsigned ENT_LD_OFS  = 0;
  localparam int unsigned ENT_WR_OFS  = 1;
  localparam int unsigned ENT_VLD_OFS = 2;

endpackage

// File: rtl/fwd_stall_ctrl_if.sv
// Decode-side bundle: decode drives the instruction fields, the controller returns
// forward selects, stall/bubble and the stall counter.
interface fwd_stall_ctrl_if #(
  parameter int unsigned REG_ADDR_W   = 3,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned CNT_W        = 16
);

  logic                                 id_valid;
  logic [NUM_RD_PORTS*REG_ADDR_W-1:0]   id_rd_addr;
  logic [NUM_RD_PORTS-1:0]              id_rd_used;
  logic                                 id_wr_en;
  logic [REG_ADDR_W-1:0]                id_wr_addr;
  logic                                 id_is_load;
  logic                                 flush;
  logic [2*NUM_RD_PORTS-1:0]            fwd_sel;
  logic                                 stall;
  logic                                 bubble;
  logic [CNT_W-1:0]                     stall_count;

  modport master (
    output id_valid, id_rd_addr, id_rd_used, id_wr_en, id_wr_addr, id_is_load, flush,
    input  fwd_sel, stall, bubble, stall_count
  );

  modport slave (
    input  id_valid, id_rd_addr, id_rd_used, id_wr_en, id_wr_addr, id_is_load, flush,
    output fwd_sel, stall, bubble, stall_count
  );

endinterface

// File: rtl/fwd_stall_ctrl_hz_port_cmp.sv
// Per-read-port hazard compare against the EX/MEM/WB shadow entries; youngest writer
// wins, and a load still in EX is reported as load-use instead of forwarded.
module fwd_stall_ctrl_hz_port_cmp
  import fwd_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = 3
) (
  input  logic [REG_ADDR_W+ENT_FLAG_W-1:0] i_ex,
  input  logic [REG_ADDR_W+ENT_FLAG_W-1:0] i_mem,
  input  logic [REG_ADDR_W+ENT_FLAG_W-1:0] i_wb,
  input  logic [REG_ADDR_W-1:0]            i_rd_addr,
  input  logic                             i_rd_used,
  output logic [1:0]                       o_fwd_sel,
  output logic                             o_load_use
);

  logic w_hit_ex, w_hit_mem, w_hit_wb, w_ex_ld;
  logic w_unused;

  assign w_hit_ex  = i_ex[REG_ADDR_W+ENT_VLD_OFS] & i_ex[REG_ADDR_W+ENT_WR_OFS] &
                     i_rd_used & (i_ex[REG_ADDR_W-1:0] == i_rd_addr);
  assign w_hit_mem = i_mem[REG_ADDR_W+ENT_VLD_OFS] & i_mem[REG_ADDR_W+ENT_WR_OFS] &
                     i_rd_used & (i_mem[REG_ADDR_W-1:0] == i_rd_addr);
  assign w_hit_wb  = i_wb[REG_ADDR_W+ENT_VLD_OFS] & i_wb[REG_ADDR_W+ENT_WR_OFS] &
                     i_rd_used & (i_wb[REG_ADDR_W-1:0] == i_rd_addr);
  assign w_ex_ld   = i_ex[REG_ADDR_W+ENT_LD_OFS];

  // Load data is forwardable from MEM onward, so the ld flag only matters in EX.
  assign w_unused = i_mem[REG_ADDR_W+ENT_LD_OFS] ^ i_wb[REG_ADDR_W+ENT_LD_OFS];

  always_comb begin
    o_fwd_sel  = FWD_RF;
    o_load_use = 1'b0;
    if (w_hit_ex && w_ex_ld) begin
      o_load_use = 1'b1;
    end else if (w_hit_ex) begin
      o_fwd_sel = FWD_EX;
    end else if (w_hit_mem) begin
      o_fwd_sel = FWD_MEM;
    end else if (w_hit_wb) begin
      o_fwd_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/fwd_stall_ctrl.sv
// Forwarding/stall controller: shadow EX/MEM/WB pipeline of in-flight writers, per-port
// forward selects, single-bubble load-use stall and a saturating stall counter.
module fwd_stall_ctrl
  import fwd_stall_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_W   = 3,
  parameter int unsigned NUM_RD_PORTS = 2,
  parameter int unsigned CNT_W        = 16
) (
  input  logic           i_clk,
  input  logic           i_rst,
  fwd_stall_ctrl_if.slave bus
);

  localparam int unsigned EntW = REG_ADDR_W + ENT_FLAG_W;

  logic [EntW-1:0]           r_ex, r_mem, r_wb;
  logic [CNT_W-1:0]          r_cnt;
  logic [EntW-1:0]           w_ex_next;
  logic [NUM_RD_PORTS-1:0]   w_load_use;
  logic [2*NUM_RD_PORTS-1:0] w_fwd_sel;
  logic                      w_stall;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
    fwd_stall_ctrl_hz_port_cmp #(
      .REG_ADDR_W (REG_ADDR_W)
    ) u_cmp (
      .i_ex       (r_ex),
      .i_mem      (r_mem),
      .i_wb       (r_wb),
      .i_rd_addr  (bus.id_rd_addr[p*REG_ADDR_W +: REG_ADDR_W]),
      .i_rd_used  (bus.id_rd_used[p]),
      .o_fwd_sel  (w_fwd_sel[2*p +: 2]),
      .o_load_use (w_load_use[p])
    );
  end

  // A flushed instruction never stalls: it is being killed anyway.
  assign w_stall = bus.id_valid & ~bus.flush & (|w_load_use);

  assign bus.fwd_sel     = w_fwd_sel;
  assign bus.stall       = w_stall;
  assign bus.bubble      = w_stall | bus.flush;
  assign bus.stall_count = r_cnt;

  assign w_ex_next = (w_stall || bus.flush || !bus.id_valid) ? '0 :
                     {1'b1, bus.id_wr_en, bus.id_is_load, bus.id_wr_addr};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ex  <= '0;
      r_mem <= '0;
      r_wb  <= '0;
      r_cnt <= '0;
    end else begin
      r_ex  <= w_ex_next;
      r_mem <= r_ex;
      r_wb  <= r_mem;
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

endmodule
